hood_mode_ctrl: RTL and testbench

Mode sequencer for the range-hood datapath. It decodes user commands into a gear state, enforces the one-shot hurricane rule, and times the hurricane, exit-delay and self-clean intervals. It drives the 3-bit mode code consumed by the timekeeping/display datapath (000 standby, 001 level 1, 010 level 2, 011 hurricane) plus a shared remaining-seconds value. Optionally it tracks cumulative run time and raises a cleaning reminder.

---
 rtl/hood_pkg.sv | 38 +++
 rtl/hood_countdown.sv | 37 +++
 rtl/hood_mode_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_hood_mode_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/hood_pkg.sv
// Shared types and encodings for the range-hood mode sequencer.
// State enum (values equal the mode_state codes), command codes, mode codes.
package hood_pkg;

    localparam logic [2:0] CMD_NONE  = 3'd0;
    localparam logic [2:0] CMD_L1    = 3'd1;
    localparam logic [2:0] CMD_L2    = 3'd2;
    localparam logic [2:0] CMD_HURR  = 3'd3;
    localparam logic [2:0] CMD_STOP  = 3'd4;
    localparam logic [2:0] CMD_CLEAN = 3'd5;
    localparam logic [2:0] CMD_POWER = 3'd6;
    localparam logic [2:0] CMD_RSVD  = 3'd7;

    localparam logic [2:0] MODE_STANDBY = 3'b000;
    localparam logic [2:0] MODE_L1      = 3'b001;
    localparam logic [2:0] MODE_L2      = 3'b010;
    localparam logic [2:0] MODE_HURR    = 3'b011;
    localparam logic [2:0] MODE_CLEAN   = 3'b100;
    localparam logic [2:0] MODE_EXIT    = 3'b101;
    localparam logic [2:0] MODE_OFF     = 3'b110;

    // State codes double as the mode_state output encoding.
    typedef enum logic [2:0] {
        S_STANDBY = MODE_STANDBY,
        S_L1      = MODE_L1,
        S_L2      = MODE_L2,
        S_HURR    = MODE_HURR,
        S_CLEAN   = MODE_CLEAN,
        S_EXIT    = MODE_EXIT,
        S_OFF     = MODE_OFF
    } state_t;

    function automatic logic is_timed(state_t s);
        return (s == S_HURR) || (s == S_EXIT) ||
               (s == S_CLEAN);
    endfunction

endpackage

// File: rtl/hood_countdown.sv
// 8-bit loadable down-counter shared by all timed hood states.
// Ports: clk_1hz, rst (async low), load_i, load_val_i, en_i -> count_o, expire_o.
module hood_countdown (
    input  logic       clk_1hz,
    input  logic       rst,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic       en_i,
    output logic [7:0] count_o,
    output logic       expire_o
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != 8'd0)) begin
            // Decrementing from 1 lands on 0 on the exit tick.
            count_d = count_q - 8'd1;
        end
    end

    always_ff @(posedge clk_1hz or negedge rst) begin
        if (!rst) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o  = count_q;
    assign expire_o = en_i && (count_q == 8'd1);

endmodule

// File: rtl/hood_mode_ctrl.sv
// Range-hood mode sequencer: command decode, one-shot hurricane, timed states.
// Ports: clk_1hz, rst, cmd_code -> mode_state, countdown_sec, hurricane_used,
// clean_remind. Macro HOOD_CLEAN_REMIND_EN builds the run-time reminder.
module hood_mode_ctrl
    import hood_pkg::*;
#(
    parameter int HURRICANE_SEC  = 60,
    parameter int EXIT_DELAY_SEC = 60,
    parameter int CLEAN_SEC      = 180
`ifdef HOOD_CLEAN_REMIND_EN
    ,
    parameter int REMIND_SEC     = 36000
`endif
) (
    input  logic       clk_1hz,
    input  logic       rst,
    input  logic [2:0] cmd_code,
    output logic [2:0] mode_state,
    output logic [7:0] countdown_sec,
    output logic       hurricane_used,
    output logic       clean_remind
);

    localparam logic [7:0] HURR_LD  = 8'(HURRICANE_SEC);
    localparam logic [7:0] EXIT_LD  = 8'(EXIT_DELAY_SEC);
    localparam logic [7:0] CLEAN_LD = 8'(CLEAN_SEC);

    state_t     state_q;
    state_t     state_d;
    logic [2:0] cmd_q;
    logic       used_q;
    logic       used_d;
    logic       new_cmd;
    logic       ld;
    logic [7:0] ld_val;
    logic       cd_en;
    logic [7:0] cd_cnt;
    logic       expire;

    // Only a 0 -> valid-code edge counts; 7 is reserved.
    assign new_cmd = (cmd_q == CMD_NONE) &&
                     (cmd_code != CMD_NONE) &&
                     (cmd_code != CMD_RSVD);

    assign cd_en = is_timed(state_q);

    always_comb begin
        state_d = state_q;
        used_d  = used_q;
        ld      = 1'b0;
        ld_val  = 8'd0;
        unique case (state_q)
            S_OFF: begin
                if (new_cmd && (cmd_code == CMD_POWER))
                    state_d = S_STANDBY;
            end
            S_STANDBY: begin
                if (new_cmd) begin
                    case (cmd_code)
                        CMD_L1:    state_d = S_L1;
                        CMD_L2:    state_d = S_L2;
                        CMD_HURR:
                            if (!used_q) state_d = S_HURR;
                        CMD_CLEAN: state_d = S_CLEAN;
                        CMD_POWER: state_d = S_OFF;
                        default:   state_d = state_q;
                    endcase
                end
            end
            S_L1, S_L2: begin
                if (new_cmd) begin
                    case (cmd_code)
                        CMD_L1:    state_d = S_L1;
                        CMD_L2:    state_d = S_L2;
                        CMD_HURR:
                            if (!used_q) state_d = S_HURR;
                        CMD_STOP:  state_d = S_STANDBY;
                        CMD_POWER: state_d = S_OFF;
                        default:   state_d = state_q;
                    endcase
                end
            end
            S_HURR: begin
                // Expiry beats a same-tick STOP.
                if (expire)
                    state_d = S_L2;
                else if (new_cmd && (cmd_code == CMD_STOP))
                    state_d = S_EXIT;
            end
            S_EXIT: begin
                if (expire) state_d = S_STANDBY;
            end
            S_CLEAN: begin
                if (expire) state_d = S_STANDBY;
            end
            default: state_d = S_OFF;
        endcase

        // Entry actions keyed on the state change.
        if (state_d != state_q) begin
            case (state_d)
                S_HURR: begin
                    ld     = 1'b1;
                    ld_val = HURR_LD;
                    used_d = 1'b1;
                end
                S_EXIT: begin
                    ld     = 1'b1;
                    ld_val = EXIT_LD;
                end
                S_CLEAN: begin
                    ld     = 1'b1;
                    ld_val = CLEAN_LD;
                end
                S_OFF:   used_d = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_1hz or negedge rst) begin
        if (!rst) begin
            state_q <= S_OFF;
            used_q  <= 1'b0;
            cmd_q   <= CMD_NONE;
        end else begin
            state_q <= state_d;
            used_q  <= used_d;
            cmd_q   <= cmd_code;
        end
    end

    hood_countdown u_cd (
        .clk_1hz    (clk_1hz),
        .rst        (rst),
        .load_i     (ld),
        .load_val_i (ld_val),
        .en_i       (cd_en),
        .count_o    (cd_cnt),
        .expire_o   (expire)
    );

`ifdef HOOD_CLEAN_REMIND_EN
    localparam logic [15:0] REMIND_LIM = 16'(REMIND_SEC);

    logic [15:0] run_q;
    logic [15:0] run_d;
    logic        running;

    assign running = (state_q == S_L1) ||
                     (state_q == S_L2) ||
                     (state_q == S_HURR) ||
                     (state_q == S_EXIT);

    always_comb begin
        run_d = run_q;
        // Only a completed clean resets the run time.
        if ((state_q == S_CLEAN) && expire)
            run_d = 16'd0;
        else if (running && (run_q < REMIND_LIM))
            run_d = run_q + 16'd1;
    end

    always_ff @(posedge clk_1hz or negedge rst) begin
        if (!rst) begin
            run_q <= 16'd0;
        end else begin
            run_q <= run_d;
        end
    end

    assign clean_remind = (run_q >= REMIND_LIM);
`else
    assign clean_remind = 1'b0;
`endif

    assign mode_state     = state_q;
    assign countdown_sec  = cd_cnt;
    assign hurricane_used = used_q;

endmodule

// File: tb/tb_hood_mode_ctrl.sv
// Directed scoreboard bench for hood_mode_ctrl.
// Stimulus pushes expected outputs; a monitor pops and compares each tick.
module tb_hood_mode_ctrl;

`ifdef HOOD_CLEAN_REMIND_EN
    localparam bit REM_EN = 1'b1;
`else
    localparam bit REM_EN = 1'b0;
`endif

    logic       clk_1hz;
    logic       rst;
    logic [2:0] cmd_code;
    logic [2:0] mode_state;
    logic [7:0] countdown_sec;
    logic       hurricane_used;
    logic       clean_remind;

    typedef struct {
        logic [2:0] mode;
        logic [7:0] cd;
        logic       used;
        int         rem;
        string      name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

`ifdef HOOD_CLEAN_REMIND_EN
    hood_mode_ctrl #(
        .HURRICANE_SEC  (60),
        .EXIT_DELAY_SEC (60),
        .CLEAN_SEC      (180),
        .REMIND_SEC     (10)
    ) dut (
        .clk_1hz        (clk_1hz),
        .rst            (rst),
        .cmd_code       (cmd_code),
        .mode_state     (mode_state),
        .countdown_sec  (countdown_sec),
        .hurricane_used (hurricane_used),
        .clean_remind   (clean_remind)
    );
`else
    hood_mode_ctrl #(
        .HURRICANE_SEC  (60),
        .EXIT_DELAY_SEC (60),
        .CLEAN_SEC      (180)
    ) dut (
        .clk_1hz        (clk_1hz),
        .rst            (rst),
        .cmd_code       (cmd_code),
        .mode_state     (mode_state),
        .countdown_sec  (countdown_sec),
        .hurricane_used (hurricane_used),
        .clean_remind   (clean_remind)
    );
`endif

    initial begin
        clk_1hz = 1'b0;
        forever #5 clk_1hz = ~clk_1hz;
    end

    // rem: 0/1 exact, -1 don't care; forced to 0 when feature absent.
    function automatic bit rem_ok(int rem, logic act);
        if (!REM_EN) return act == 1'b0;
        if (rem < 0) return 1'b1;
        return act == rem[0];
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_1hz);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (mode_state !== e.mode ||
                    countdown_sec !== e.cd ||
                    hurricane_used !== e.used ||
                    !rem_ok(e.rem, clean_remind)) begin
                    errors++;
                    $display("FAIL %s: got mode=%0d cd=%0d used=%0d rem=%0d want mode=%0d cd=%0d used=%0d rem=%0d",
                             e.name, mode_state, countdown_sec,
                             hurricane_used, clean_remind,
                             e.mode, e.cd, e.used, e.rem);
                end
            end
        end
    end

    task automatic step(input logic [2:0] c,
                        input logic [2:0] m,
                        input logic [7:0] cd,
                        input logic u,
                        input int r,
                        input string n);
        exp_t e;
        @(negedge clk_1hz);
        cmd_code = c;
        e.mode = m;
        e.cd   = cd;
        e.used = u;
        e.rem  = r;
        e.name = n;
        q.push_back(e);
    endtask

    initial begin : stim
        rst      = 1'b0;
        cmd_code = 3'd0;

        step(0, 3'b110, 0, 0, 0, "reset0");
        step(0, 3'b110, 0, 0, 0, "reset1");
        @(negedge clk_1hz);
        rst = 1'b1;
        step(0, 3'b110, 0, 0, 0, "off_idle");

        step(6, 3'b000, 0, 0, 0, "power_on");
        step(0, 3'b000, 0, 0, 0, "stby");
        step(1, 3'b001, 0, 0, 0, "l1");
        for (int i = 1; i <= 10; i++)
            step(0, 3'b001, 0, 0, (i >= 10) ? 1 : 0, "l1_run");

        step(4, 3'b000, 0, 0, 1, "stop_l1");
        step(0, 3'b000, 0, 0, 1, "stby2");
        step(5, 3'b100, 180, 0, 1, "clean");
        for (int i = 1; i <= 179; i++)
            step((i == 50) ? 3'd4 : 3'd0, 3'b100,
                 8'(180 - i), 0, 1, "clean_cnt");
        step(0, 3'b000, 0, 0, 0, "clean_done");

        step(2, 3'b010, 0, 0, -1, "l2");
        step(0, 3'b010, 0, 0, -1, "l2_idle");
        step(3, 3'b011, 60, 1, -1, "hurr");
        for (int i = 1; i <= 59; i++)
            step((i == 10) ? 3'd3 : (i == 20) ? 3'd1 : 3'd0,
                 3'b011, 8'(60 - i), 1, -1, "hurr_cnt");
        step(0, 3'b010, 0, 1, -1, "hurr_exp");
        step(3, 3'b010, 0, 1, -1, "hurr_again");
        step(0, 3'b010, 0, 1, -1, "l2_idle2");

        step(6, 3'b110, 0, 0, -1, "power_off");
        step(0, 3'b110, 0, 0, -1, "off2");
        step(6, 3'b000, 0, 0, -1, "power_on2");
        step(0, 3'b000, 0, 0, -1, "stby3");
        step(3, 3'b011, 60, 1, -1, "hurr2");
        for (int i = 1; i <= 30; i++)
            step(0, 3'b011, 8'(60 - i), 1, -1, "hurr2_cnt");
        step(4, 3'b101, 60, 1, -1, "exit");
        for (int i = 1; i <= 59; i++)
            step((i == 5) ? 3'd1 : 3'd0, 3'b101,
                 8'(60 - i), 1, -1, "exit_cnt");
        step(0, 3'b000, 0, 1, -1, "exit_done");

        step(6, 3'b110, 0, 0, -1, "hold_pwr");
        for (int i = 0; i < 4; i++)
            step(6, 3'b110, 0, 0, -1, "hold_pwr_n");
        step(0, 3'b110, 0, 0, -1, "off3");
        step(6, 3'b000, 0, 0, -1, "power_on3");
        step(1, 3'b000, 0, 0, -1, "nz_to_nz");
        step(0, 3'b000, 0, 0, -1, "stby4");

        step(1, 3'b001, 0, 0, -1, "l1b");
        step(0, 3'b001, 0, 0, -1, "l1b_idle");
        step(3, 3'b011, 60, 1, -1, "hurr3");
        for (int i = 1; i <= 59; i++)
            step(0, 3'b011, 8'(60 - i), 1, -1, "hurr3_cnt");
        step(4, 3'b010, 0, 1, -1, "stop_on_exp");
        step(0, 3'b010, 0, 1, -1, "l2_after");
        step(7, 3'b010, 0, 1, -1, "rsvd");
        step(0, 3'b010, 0, 1, -1, "l2_after2");

        step(4, 3'b000, 0, 1, -1, "stop_l2");
        step(0, 3'b000, 0, 1, -1, "stby5");
        step(5, 3'b100, 180, 1, -1, "clean2");
        for (int i = 1; i <= 130; i++)
            step(0, 3'b100, 8'(180 - i), 1, -1, "clean2_cnt");

        // Asynchronous reset mid-clean, checked before any clock edge.
        @(negedge clk_1hz);
        rst = 1'b0;
        #1;
        checks++;
        if (mode_state !== 3'b110 || countdown_sec !== 8'd0 ||
            hurricane_used !== 1'b0 || clean_remind !== 1'b0) begin
            errors++;
            $display("FAIL async_rst: got mode=%0d cd=%0d used=%0d rem=%0d want 6 0 0 0",
                     mode_state, countdown_sec,
                     hurricane_used, clean_remind);
        end
        step(0, 3'b110, 0, 0, 0, "rst_hold");
        @(negedge clk_1hz);
        rst = 1'b1;
        step(0, 3'b110, 0, 0, 0, "rst_rel");
        step(6, 3'b000, 0, 0, 0, "power_on4");
        step(0, 3'b000, 0, 0, 0, "stby6");

        repeat (3) @(posedge clk_1hz);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
